// File: rtl/id_ctrl_pipe.sv
// ID-stage controller: decodes the ID instruction into the ID/EX control bundle and
// handles load-use stalls, taken-branch flushes and MULT/DIV occupancy sequencing.
module id_ctrl_pipe #(
  parameter int MDU_LAT = 32,
  parameter int HAZ_EN  = 1,
  parameter int RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic            id_bresult,
  output logic            stall,
  output logic            flush_if,
  output logic            id_pcsel,
  output logic [1:0]      id_npcop,
  output logic [2:0]      id_extop,
  output logic            ex_valid,
  output logic [3:0]      ex_aluop,
  output logic            ex_alusrcb,
  output logic            ex_rfwr,
  output logic            ex_dmwr,
  output logic            ex_memrd,
  output logic [1:0]      ex_wbsel,
  output logic [RA_W-1:0] ex_rw,
  output logic            ex_illegal,
  output logic            mdu_start,
  output logic            mdu_busy,
  output logic            mdu_done
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00, FUNCT_SRL  = 6'h02, FUNCT_SRA  = 6'h03, FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09, FUNCT_MFHI = 6'h10, FUNCT_MTHI = 6'h11, FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MTLO = 6'h13, FUNCT_MULT = 6'h18, FUNCT_MULTU = 6'h19, FUNCT_DIV = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B, FUNCT_ADD  = 6'h20, FUNCT_ADDU = 6'h21, FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23, FUNCT_AND  = 6'h24, FUNCT_OR   = 6'h25, FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27, FUNCT_SLT  = 6'h2A, FUNCT_SLTU = 6'h2B;

  localparam logic [3:0] ALUop_ADD = 4'd0, ALUop_SUB = 4'd1, ALUop_AND = 4'd2,  ALUop_OR   = 4'd3;
  localparam logic [3:0] ALUop_XOR = 4'd4, ALUop_NOR = 4'd5, ALUop_SLT = 4'd6,  ALUop_SLTU = 4'd7;
  localparam logic [3:0] ALUop_SLL = 4'd8, ALUop_SRL = 4'd9, ALUop_SRA = 4'd10, ALUop_LUI  = 4'd11;

  localparam logic [1:0] NPC_NORMAL = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_RF = 2'd3;
  localparam logic [2:0] EXT_ZERO = 3'd0, EXT_SIGN = 3'd1, EXT_LUI = 3'd2, EXT_BRANCH = 3'd3;
  localparam logic [1:0] WB_DM = 2'b00, WB_ALU = 2'b01, WB_PC = 2'b10;

  localparam logic [7:0] CNT_LOAD = 8'(MDU_LAT - 1);

  typedef enum logic {S_IDLE, S_BUSY} mdu_state_t;

  logic [5:0]      op_p0, fn_p0;
  logic [RA_W-1:0] rs_p0, rt_p0, rd_p0, rw_p0;
  logic            legal_p0, alusrcb_p0, rfwr_p0, dmwr_p0, memrd_p0;
  logic            rt_src_p0, mdu_cls_p0, mdu_go_p0, is_br_p0, is_jmp_p0;
  logic [3:0]      aluop_p0;
  logic [1:0]      wbsel_p0, npcop_p0;
  logic [2:0]      extop_p0;
  logic            lu_stall_p0, mdu_stall_p0, issue_p0, taken_p0;
  logic            unused_shamt;
  mdu_state_t      state;
  logic [7:0]      count;

  assign op_p0 = id_instr[31:26];
  assign fn_p0 = id_instr[5:0];
  assign rs_p0 = RA_W'(id_instr[25:21]);
  assign rt_p0 = RA_W'(id_instr[20:16]);
  assign rd_p0 = RA_W'(id_instr[15:11]);
  assign unused_shamt = ^id_instr[10:6];

  always_comb begin
    legal_p0   = 1'b1;
    aluop_p0   = ALUop_ADD;
    alusrcb_p0 = 1'b0;
    rfwr_p0    = 1'b0;
    dmwr_p0    = 1'b0;
    memrd_p0   = 1'b0;
    wbsel_p0   = WB_ALU;
    extop_p0   = EXT_ZERO;
    npcop_p0   = NPC_NORMAL;
    rt_src_p0  = 1'b0;
    mdu_cls_p0 = 1'b0;
    mdu_go_p0  = 1'b0;
    is_br_p0   = 1'b0;
    is_jmp_p0  = 1'b0;
    rw_p0      = (op_p0 == OP_RTYPE) ? rd_p0 : (op_p0 == OP_JAL) ? RA_W'(31) : rt_p0;
    case (op_p0)
      OP_RTYPE: begin
        case (fn_p0)
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR, FUNCT_XOR,
          FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU, FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
            rfwr_p0   = 1'b1;
            rt_src_p0 = 1'b1;
            case (fn_p0)
              FUNCT_SUB, FUNCT_SUBU: aluop_p0 = ALUop_SUB;
              FUNCT_AND:             aluop_p0 = ALUop_AND;
              FUNCT_OR:              aluop_p0 = ALUop_OR;
              FUNCT_XOR:             aluop_p0 = ALUop_XOR;
              FUNCT_NOR:             aluop_p0 = ALUop_NOR;
              FUNCT_SLT:             aluop_p0 = ALUop_SLT;
              FUNCT_SLTU:            aluop_p0 = ALUop_SLTU;
              FUNCT_SLL:             aluop_p0 = ALUop_SLL;
              FUNCT_SRL:             aluop_p0 = ALUop_SRL;
              FUNCT_SRA:             aluop_p0 = ALUop_SRA;
              default:               aluop_p0 = ALUop_ADD;
            endcase
          end
          FUNCT_JR: begin
            npcop_p0  = NPC_RF;
            is_jmp_p0 = 1'b1;
          end
          FUNCT_JALR: begin
            npcop_p0  = NPC_RF;
            is_jmp_p0 = 1'b1;
            rfwr_p0   = 1'b1;
            wbsel_p0  = WB_PC;
          end
          FUNCT_MFHI, FUNCT_MFLO: begin
            rfwr_p0    = 1'b1;
            mdu_cls_p0 = 1'b1;
          end
          FUNCT_MTHI, FUNCT_MTLO: mdu_cls_p0 = 1'b1;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            mdu_cls_p0 = 1'b1;
            mdu_go_p0  = 1'b1;
            rt_src_p0  = 1'b1;
          end
          default: legal_p0 = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        rfwr_p0    = 1'b1;
        alusrcb_p0 = 1'b1;
        case (op_p0)
          OP_SLTI:  begin aluop_p0 = ALUop_SLT;  extop_p0 = EXT_SIGN; end
          OP_SLTIU: begin aluop_p0 = ALUop_SLTU; extop_p0 = EXT_SIGN; end
          OP_ANDI:  aluop_p0 = ALUop_AND;
          OP_ORI:   aluop_p0 = ALUop_OR;
          OP_XORI:  aluop_p0 = ALUop_XOR;
          OP_LUI:   begin aluop_p0 = ALUop_LUI;  extop_p0 = EXT_LUI;  end
          default:  extop_p0 = EXT_SIGN;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        rfwr_p0    = 1'b1;
        alusrcb_p0 = 1'b1;
        memrd_p0   = 1'b1;
        wbsel_p0   = WB_DM;
        extop_p0   = EXT_SIGN;
      end
      OP_SB, OP_SH, OP_SW: begin
        dmwr_p0    = 1'b1;
        alusrcb_p0 = 1'b1;
        rt_src_p0  = 1'b1;
        extop_p0   = EXT_SIGN;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        aluop_p0  = ALUop_SUB;
        extop_p0  = EXT_BRANCH;
        npcop_p0  = NPC_BRANCH;
        is_br_p0  = 1'b1;
        rt_src_p0 = (op_p0 == OP_BEQ) || (op_p0 == OP_BNE);
      end
      OP_J, OP_JAL: begin
        npcop_p0  = NPC_JUMP;
        is_jmp_p0 = 1'b1;
        if (op_p0 == OP_JAL) begin
          rfwr_p0  = 1'b1;
          wbsel_p0 = WB_PC;
        end
      end
      default: legal_p0 = 1'b0;
    endcase
  end

  // Load-use hazard is judged against the ID/EX bundle; HI/LO users wait out the MDU until its done cycle.
  assign lu_stall_p0  = (HAZ_EN != 0) && ex_valid && ex_memrd && (ex_rw != '0) &&
                        ((ex_rw == rs_p0) || (rt_src_p0 && (ex_rw == rt_p0)));
  assign mdu_stall_p0 = id_valid && mdu_cls_p0 && mdu_busy && !mdu_done;
  assign stall        = lu_stall_p0 || mdu_stall_p0;
  assign issue_p0     = id_valid && !stall;
  assign taken_p0     = (is_br_p0 && id_bresult) || is_jmp_p0;
  assign flush_if     = issue_p0 && taken_p0;
  assign id_pcsel     = !flush_if;
  assign id_npcop     = npcop_p0;
  assign id_extop     = extop_p0;
  assign mdu_busy     = (state == S_BUSY);

  // ID/EX boundary
  always_ff @(posedge clk) begin
    if (rst || !issue_p0) begin
      ex_valid   <= 1'b0;
      ex_aluop   <= '0;
      ex_alusrcb <= 1'b0;
      ex_rfwr    <= 1'b0;
      ex_dmwr    <= 1'b0;
      ex_memrd   <= 1'b0;
      ex_wbsel   <= '0;
      ex_rw      <= '0;
      ex_illegal <= 1'b0;
      mdu_start  <= 1'b0;
    end else begin
      ex_valid   <= 1'b1;
      ex_aluop   <= aluop_p0;
      ex_alusrcb <= alusrcb_p0;
      ex_rfwr    <= rfwr_p0 && (rw_p0 != '0);
      ex_dmwr    <= dmwr_p0;
      ex_memrd   <= memrd_p0;
      ex_wbsel   <= wbsel_p0;
      ex_rw      <= rw_p0;
      ex_illegal <= !legal_p0;
      mdu_start  <= mdu_go_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      mdu_done <= 1'b0;
    end else if (issue_p0 && mdu_go_p0) begin
      state    <= S_BUSY;
      count    <= CNT_LOAD;
      mdu_done <= 1'b0;
    end else if (state == S_BUSY) begin
      if (count == '0) begin
        state    <= S_IDLE;
        mdu_done <= 1'b0;
      end else begin
        count    <= count - 8'd1;
        mdu_done <= (count == 8'd1);
      end
    end else begin
      mdu_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against an instruction-level pipeline model.
module tb_id_ctrl_pipe;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst, id_valid, id_bresult;
  logic [31:0] id_instr;

  logic stall, flush_if, id_pcsel, ex_valid, ex_alusrcb, ex_rfwr, ex_dmwr, ex_memrd, ex_illegal;
  logic mdu_start, mdu_busy, mdu_done;
  logic [1:0] id_npcop, ex_wbsel;
  logic [2:0] id_extop;
  logic [3:0] ex_aluop;
  logic [4:0] ex_rw;

  logic stall_n, flush_n, pcsel_n, valid_n, srcb_n, rfwr_n, dmwr_n, memrd_n, ill_n, start_n, busy_n, done_n;
  logic [1:0] npcop_n, wbsel_n;
  logic [2:0] extop_n;
  logic [3:0] aluop_n;
  logic [4:0] rw_n;

  int n_chk = 0;
  int n_fail = 0;

  id_ctrl_pipe #(.MDU_LAT(LAT), .HAZ_EN(1), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_bresult(id_bresult),
    .stall(stall), .flush_if(flush_if), .id_pcsel(id_pcsel), .id_npcop(id_npcop), .id_extop(id_extop),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_alusrcb(ex_alusrcb), .ex_rfwr(ex_rfwr),
    .ex_dmwr(ex_dmwr), .ex_memrd(ex_memrd), .ex_wbsel(ex_wbsel), .ex_rw(ex_rw), .ex_illegal(ex_illegal),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_done(mdu_done));

  id_ctrl_pipe #(.MDU_LAT(LAT), .HAZ_EN(0), .RA_W(5)) dut_nohaz (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_bresult(id_bresult),
    .stall(stall_n), .flush_if(flush_n), .id_pcsel(pcsel_n), .id_npcop(npcop_n), .id_extop(extop_n),
    .ex_valid(valid_n), .ex_aluop(aluop_n), .ex_alusrcb(srcb_n), .ex_rfwr(rfwr_n),
    .ex_dmwr(dmwr_n), .ex_memrd(memrd_n), .ex_wbsel(wbsel_n), .ex_rw(rw_n), .ex_illegal(ill_n),
    .mdu_start(start_n), .mdu_busy(busy_n), .mdu_done(done_n));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       legal;
    logic [3:0] alu;
    logic       srcb;
    logic       wr;
    logic       dmwr;
    logic       memrd;
    logic [1:0] wb;
    logic [4:0] rw;
    logic [2:0] ext;
    logic [1:0] npc;
    logic       rt_src;
    logic       mdu_cls;
    logic       mdu_go;
    logic       br;
    logic       jmp;
  } info_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu;
    logic       srcb;
    logic       rfwr;
    logic       dmwr;
    logic       memrd;
    logic [1:0] wb;
    logic [4:0] rw;
    logic       ill;
    logic       start;
  } ex_t;

  ex_t m_ex;
  int  m_left;
  bit  m_armed = 1'b0;

  // What each instruction means, written mnemonic by mnemonic.
  function automatic info_t spec_dec(input logic [31:0] ins);
    info_t d;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    d = '0;
    d.legal = 1'b1;
    d.wb = 2'b01;
    d.rw = (op == 6'h00) ? ins[15:11] : (op == 6'h03) ? 5'd31 : ins[20:16];
    if (op == 6'h00) begin
      case (fn)
        6'h20, 6'h21: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd0; end
        6'h22, 6'h23: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd1; end
        6'h24: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd2; end
        6'h25: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd3; end
        6'h26: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd4; end
        6'h27: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd5; end
        6'h2A: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd6; end
        6'h2B: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd7; end
        6'h00: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd8; end
        6'h02: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd9; end
        6'h03: begin d.wr = 1; d.rt_src = 1; d.alu = 4'd10; end
        6'h08: begin d.npc = 2'd3; d.jmp = 1; end
        6'h09: begin d.npc = 2'd3; d.jmp = 1; d.wr = 1; d.wb = 2'b10; end
        6'h10, 6'h12: begin d.wr = 1; d.mdu_cls = 1; end
        6'h11, 6'h13: d.mdu_cls = 1;
        6'h18, 6'h19, 6'h1A, 6'h1B: begin d.mdu_cls = 1; d.mdu_go = 1; d.rt_src = 1; end
        default: d.legal = 1'b0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09: begin d.wr = 1; d.srcb = 1; d.ext = 3'd1; end
        6'h0A: begin d.wr = 1; d.srcb = 1; d.ext = 3'd1; d.alu = 4'd6; end
        6'h0B: begin d.wr = 1; d.srcb = 1; d.ext = 3'd1; d.alu = 4'd7; end
        6'h0C: begin d.wr = 1; d.srcb = 1; d.alu = 4'd2; end
        6'h0D: begin d.wr = 1; d.srcb = 1; d.alu = 4'd3; end
        6'h0E: begin d.wr = 1; d.srcb = 1; d.alu = 4'd4; end
        6'h0F: begin d.wr = 1; d.srcb = 1; d.alu = 4'd11; d.ext = 3'd2; end
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin d.wr = 1; d.srcb = 1; d.memrd = 1; d.wb = 2'b00; d.ext = 3'd1; end
        6'h28, 6'h29, 6'h2B: begin d.dmwr = 1; d.srcb = 1; d.rt_src = 1; d.ext = 3'd1; end
        6'h04, 6'h05: begin d.alu = 4'd1; d.ext = 3'd3; d.npc = 2'd1; d.br = 1; d.rt_src = 1; end
        6'h06, 6'h07: begin d.alu = 4'd1; d.ext = 3'd3; d.npc = 2'd1; d.br = 1; end
        6'h02: begin d.npc = 2'd2; d.jmp = 1; end
        6'h03: begin d.npc = 2'd2; d.jmp = 1; d.wr = 1; d.wb = 2'b10; end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

  function automatic logic m_stall(input logic v, input logic [31:0] ins);
    info_t d;
    logic lu, md;
    d  = spec_dec(ins);
    lu = m_ex.valid && m_ex.memrd && (m_ex.rw != 5'd0) &&
         ((m_ex.rw == ins[25:21]) || (d.rt_src && (m_ex.rw == ins[20:16])));
    md = v && d.mdu_cls && (m_left > 1);
    return lu || md;
  endfunction

  // Model: m_left counts BUSY cycles still to come including the current one.
  always @(posedge clk) begin
    info_t d;
    logic st, iss;
    if (rst) begin
      m_ex   = '0;
      m_left = 0;
      m_armed = 1'b1;
    end else begin
      d   = spec_dec(id_instr);
      st  = m_stall(id_valid, id_instr);
      iss = id_valid && !st;
      if (iss && d.mdu_go) m_left = LAT;
      else if (m_left > 0) m_left = m_left - 1;
      if (iss) begin
        m_ex.valid = 1'b1;
        m_ex.alu   = d.alu;
        m_ex.srcb  = d.srcb;
        m_ex.rfwr  = d.wr && (d.rw != 5'd0);
        m_ex.dmwr  = d.dmwr;
        m_ex.memrd = d.memrd;
        m_ex.wb    = d.wb;
        m_ex.rw    = d.rw;
        m_ex.ill   = !d.legal;
        m_ex.start = d.mdu_go;
      end else begin
        m_ex = '0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    info_t d;
    logic st, tk;
    if (m_armed) begin
      d  = spec_dec(id_instr);
      st = m_stall(id_valid, id_instr);
      tk = id_valid && !st && ((d.br && id_bresult) || d.jmp);
      chk("stall", 32'(stall), 32'(st));
      chk("flush_if", 32'(flush_if), 32'(tk));
      chk("id_pcsel", 32'(id_pcsel), 32'(!tk));
      chk("id_npcop", 32'(id_npcop), 32'(d.npc));
      chk("id_extop", 32'(id_extop), 32'(d.ext));
      chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
      chk("ex_aluop", 32'(ex_aluop), 32'(m_ex.alu));
      chk("ex_alusrcb", 32'(ex_alusrcb), 32'(m_ex.srcb));
      chk("ex_rfwr", 32'(ex_rfwr), 32'(m_ex.rfwr));
      chk("ex_dmwr", 32'(ex_dmwr), 32'(m_ex.dmwr));
      chk("ex_memrd", 32'(ex_memrd), 32'(m_ex.memrd));
      chk("ex_wbsel", 32'(ex_wbsel), 32'(m_ex.wb));
      chk("ex_rw", 32'(ex_rw), 32'(m_ex.rw));
      chk("ex_illegal", 32'(ex_illegal), 32'(m_ex.ill));
      chk("mdu_start", 32'(mdu_start), 32'(m_ex.start));
      chk("mdu_busy", 32'(mdu_busy), 32'(m_left > 0));
      chk("mdu_done", 32'(mdu_done), 32'(m_left == 1));
    end
  end

  function automatic logic [31:0] rt_i(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic apply(input logic r, input logic v, input logic [31:0] i, input logic b);
    @(posedge clk);
    #1;
    rst = r;
    id_valid = v;
    id_instr = i;
    id_bresult = b;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    logic [15:0] imm;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    case ($urandom_range(0, 27))
      0:  return rt_i(6'h20, a, b, c);
      1:  return rt_i(6'h21, a, b, c);
      2:  return rt_i(6'h22, a, b, c);
      3:  return rt_i(6'h24, a, b, c);
      4:  return rt_i(6'h25, a, b, c);
      5:  return rt_i(6'h2A, a, b, c);
      6:  return rt_i(6'h00, 5'd0, b, c);
      7:  return rt_i(6'h08, a, 5'd0, 5'd0);
      8:  return rt_i(6'h09, a, 5'd0, c);
      9:  return rt_i(6'h10, 5'd0, 5'd0, c);
      10: return rt_i(6'h12, 5'd0, 5'd0, c);
      11: return rt_i(6'h11, a, 5'd0, 5'd0);
      12: return rt_i(6'h18, a, b, 5'd0);
      13: return rt_i(6'h1B, a, b, 5'd0);
      14: return it_i(6'h08, a, b, imm);
      15: return it_i(6'h0D, a, b, imm);
      16: return it_i(6'h0F, 5'd0, b, imm);
      17: return it_i(6'h23, a, b, imm);
      18: return it_i(6'h24, a, b, imm);
      19: return it_i(6'h2B, a, b, imm);
      20: return it_i(6'h28, a, b, imm);
      21: return it_i(6'h04, a, b, imm);
      22: return it_i(6'h05, a, b, imm);
      23: return it_i(6'h06, a, 5'd0, imm);
      24: return {6'h02, 26'($urandom)};
      25: return {6'h03, 26'($urandom)};
      26: return it_i(6'h3F, a, b, imm);
      default: return rt_i(6'h3F, a, b, c);
    endcase
  endfunction

  initial begin
    logic [31:0] nop, lw3, add4, lw0, add40, beq, lw5, beq5, mult, addu, mflo, ill, ori;
    rst = 1'b1;
    id_valid = 1'b0;
    id_instr = 32'h0;
    id_bresult = 1'b0;
    nop   = 32'h0;
    lw3   = it_i(6'h23, 5'd1, 5'd3, 16'h0);
    add4  = rt_i(6'h20, 5'd3, 5'd2, 5'd4);
    lw0   = it_i(6'h23, 5'd1, 5'd0, 16'h0);
    add40 = rt_i(6'h20, 5'd0, 5'd2, 5'd4);
    beq   = it_i(6'h04, 5'd1, 5'd2, 16'h4);
    lw5   = it_i(6'h23, 5'd1, 5'd5, 16'h0);
    beq5  = it_i(6'h04, 5'd5, 5'd2, 16'h4);
    mult  = rt_i(6'h18, 5'd1, 5'd2, 5'd0);
    addu  = rt_i(6'h21, 5'd1, 5'd2, 5'd5);
    mflo  = rt_i(6'h12, 5'd0, 5'd0, 5'd6);
    ill   = it_i(6'h3F, 5'd1, 5'd2, 16'h0);
    ori   = it_i(6'h0D, 5'd1, 5'd7, 16'h5);

    apply(1, 1, lw3, 0);
    apply(1, 1, add4, 1);
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_rfwr", 32'(ex_rfwr), 32'd0);
    chk("rst_ex_aluop", 32'(ex_aluop), 32'd0);
    chk("rst_mdu_busy", 32'(mdu_busy), 32'd0);
    chk("rst_mdu_start", 32'(mdu_start), 32'd0);

    apply(0, 1, lw3, 0);
    apply(0, 1, add4, 0);
    chk("lu_stall", 32'(stall), 32'd1);
    chk("lu_nohaz_stall", 32'(stall_n), 32'd0);
    chk("lu_lw_rw", 32'(ex_rw), 32'd3);
    apply(0, 1, add4, 0);
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_stall_once", 32'(stall), 32'd0);
    apply(0, 1, nop, 0);
    chk("lu_add_rw", 32'(ex_rw), 32'd4);
    chk("lu_add_wbsel", 32'(ex_wbsel), 32'd1);

    apply(0, 1, lw0, 0);
    apply(0, 1, add40, 0);
    chk("r0_no_stall", 32'(stall), 32'd0);
    chk("r0_lw_rfwr", 32'(ex_rfwr), 32'd0);

    apply(0, 1, beq, 1);
    chk("beq_flush", 32'(flush_if), 32'd1);
    chk("beq_npcop", 32'(id_npcop), 32'd1);
    chk("beq_pcsel", 32'(id_pcsel), 32'd0);
    apply(0, 1, lw5, 0);
    apply(0, 1, beq5, 1);
    chk("beq_held_stall", 32'(stall), 32'd1);
    chk("beq_held_flush", 32'(flush_if), 32'd0);
    chk("beq_held_pcsel", 32'(id_pcsel), 32'd1);
    apply(0, 1, beq5, 1);
    chk("beq_reissue_flush", 32'(flush_if), 32'd1);

    apply(0, 1, mult, 0);
    apply(0, 1, addu, 0);
    chk("mdu_start_pulse", 32'(mdu_start), 32'd1);
    chk("mdu_busy_1", 32'(mdu_busy), 32'd1);
    chk("mdu_addu_flows", 32'(stall), 32'd0);
    apply(0, 1, mflo, 0);
    chk("mdu_start_once", 32'(mdu_start), 32'd0);
    chk("mdu_mflo_stall_2", 32'(stall), 32'd1);
    apply(0, 1, mflo, 0);
    chk("mdu_mflo_stall_3", 32'(stall), 32'd1);
    chk("mdu_busy_3", 32'(mdu_busy), 32'd1);
    apply(0, 1, mflo, 0);
    chk("mdu_done_4", 32'(mdu_done), 32'd1);
    chk("mdu_mflo_go", 32'(stall), 32'd0);
    apply(0, 1, nop, 0);
    chk("mdu_idle", 32'(mdu_busy), 32'd0);
    chk("mdu_mflo_rw", 32'(ex_rw), 32'd6);
    chk("mdu_mflo_valid", 32'(ex_valid), 32'd1);

    apply(0, 1, mult, 0);
    apply(0, 1, nop, 0);
    apply(1, 1, nop, 0);
    chk("mdu_rst_busy2", 32'(mdu_busy), 32'd1);
    apply(0, 1, nop, 0);
    chk("mdu_rst_idle", 32'(mdu_busy), 32'd0);
    chk("mdu_rst_nodone", 32'(mdu_done), 32'd0);
    apply(0, 1, nop, 0);
    chk("mdu_rst_nodone2", 32'(mdu_done), 32'd0);

    apply(0, 1, ill, 0);
    apply(0, 1, ori, 0);
    chk("ill_flag", 32'(ex_illegal), 32'd1);
    chk("ill_rfwr", 32'(ex_rfwr), 32'd0);
    chk("ill_dmwr", 32'(ex_dmwr), 32'd0);
    apply(0, 1, nop, 0);
    chk("ori_clears_ill", 32'(ex_illegal), 32'd0);
    chk("ori_rfwr", 32'(ex_rfwr), 32'd1);
    chk("ori_rw", 32'(ex_rw), 32'd7);

    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), rand_instr(), 1'($urandom));
    end
    apply(0, 0, nop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
